// File: rtl/rams_dp_rf_clr.sv
// -----------------------------------------------------------------------------
// rams_dp_rf_clr
//
// True dual-port, read-first, synchronous RAM with registered outputs, per-port
// read-valid strobes and a hardware clear sequencer that zeroes every word.
// The array is swept to zero after every reset and whenever clear_start is
// pulsed while idle. Two engines share the buffer; it is wiped between jobs.
//
// Optional feature: define RAMS_DP_OUTREG_EN to add a second output register
// stage on each port (data and valid). Read latency becomes 2 cycles. Without
// the macro there is a single output register and latency is 1 cycle.
//
// Ports
//   clock        single clock, all logic on posedge
//   reset        synchronous, active-high
//   clear_start  pulse: start a clear sweep (ignored while busy)
//   busy         high while reset is applied or a clear sweep is running
//   a_enable     port A access enable
//   a_write_en   port A write, qualified by a_enable
//   a_address    port A word address ($clog2(MEM_DEPTH) bits)
//   a_data_in    port A write data
//   a_data_out   port A registered read data (pre-write contents)
//   a_valid      a_data_out carries data from an accepted access
//   b_*          port B, same set and meaning as port A
//
// Handshake: an access is accepted when enable=1 and busy=0 in the same cycle.
// There is no back-pressure; valid follows the accepted access by the read
// latency and drops in step with enable. While busy, enables are ignored,
// valid is 0 and data_out holds.
// -----------------------------------------------------------------------------
module rams_dp_rf_clr #(
    parameter int MEM_WIDTH = 32,
    parameter int MEM_DEPTH = 1024
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          clear_start,
    output logic                          busy,
    input  logic                          a_enable,
    input  logic                          a_write_en,
    input  logic [$clog2(MEM_DEPTH)-1:0]  a_address,
    input  logic [MEM_WIDTH-1:0]          a_data_in,
    output logic [MEM_WIDTH-1:0]          a_data_out,
    output logic                          a_valid,
    input  logic                          b_enable,
    input  logic                          b_write_en,
    input  logic [$clog2(MEM_DEPTH)-1:0]  b_address,
    input  logic [MEM_WIDTH-1:0]          b_data_in,
    output logic [MEM_WIDTH-1:0]          b_data_out,
    output logic                          b_valid
);
    localparam int AW = $clog2(MEM_DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_DEPTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Clear sequencer state; state_q is the FSM state visible to checkers.
    state_t          state_q, state_d;
    logic [AW-1:0]   sweep_q, sweep_d;
    logic            busy_q, busy_d;
    logic            sweep_we;

    logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];

    // Port A/B access path
    logic                 a_acc, b_acc;
    logic                 a_we, b_we;
    logic                 a_in_range, b_in_range;
    logic [MEM_WIDTH-1:0] a_rd_word, b_rd_word;
    logic [MEM_WIDTH-1:0] a_data_q, a_data_d, b_data_q, b_data_d;
    logic                 a_valid_q, a_valid_d, b_valid_q, b_valid_d;

    // Out-of-range addresses only exist when the depth is not a power of two.
    if (MEM_DEPTH == (1 << AW)) begin : g_pow2
        assign a_in_range = 1'b1;
        assign b_in_range = 1'b1;
    end else begin : g_npow2
        localparam logic [AW:0] DEPTH_W = (AW+1)'(MEM_DEPTH);
        assign a_in_range = ({1'b0, a_address} < DEPTH_W);
        assign b_in_range = ({1'b0, b_address} < DEPTH_W);
    end

    // Clear FSM next state. busy_q tracks ST_CLEAR exactly, so it rises the
    // cycle after clear_start and falls the cycle after the last word write.
    always_comb begin
        state_d  = state_q;
        sweep_d  = sweep_q;
        busy_d   = busy_q;
        sweep_we = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clear_start) begin
                    state_d = ST_CLEAR;
                    sweep_d = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_CLEAR: begin
                sweep_we = ~reset;
                if (sweep_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    sweep_d = '0;
                    busy_d  = 1'b0;
                end else begin
                    sweep_d = sweep_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                sweep_d = '0;
                busy_d  = 1'b1;
            end
        endcase
    end

    // User accesses: read-first, so the read mux sees the pre-write contents.
    always_comb begin
        a_acc     = a_enable & ~busy_q & ~reset;
        b_acc     = b_enable & ~busy_q & ~reset;
        a_we      = a_acc & a_write_en & a_in_range;
        b_we      = b_acc & b_write_en & b_in_range;
        a_rd_word = a_in_range ? mem[a_address] : '0;
        b_rd_word = b_in_range ? mem[b_address] : '0;
        a_data_d  = a_acc ? a_rd_word : a_data_q;
        b_data_d  = b_acc ? b_rd_word : b_data_q;
        a_valid_d = a_acc;
        b_valid_d = b_acc;
    end

    // Port A is written last so it wins a same-address write collision.
    always_ff @(posedge clock) begin
        if (sweep_we) mem[sweep_q] <= '0;
        if (b_we)     mem[b_address] <= b_data_in;
        if (a_we)     mem[a_address] <= a_data_in;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            sweep_q   <= '0;
            busy_q    <= 1'b1;
            a_data_q  <= '0;
            b_data_q  <= '0;
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sweep_q   <= sweep_d;
            busy_q    <= busy_d;
            a_data_q  <= a_data_d;
            b_data_q  <= b_data_d;
            a_valid_q <= a_valid_d;
            b_valid_q <= b_valid_d;
        end
    end

    assign busy = busy_q;

`ifdef RAMS_DP_OUTREG_EN
    // Second stage shifts unconditionally so valid drops in step with enable.
    logic [MEM_WIDTH-1:0] a_data2_q, a_data2_d, b_data2_q, b_data2_d;
    logic                 a_valid2_q, a_valid2_d, b_valid2_q, b_valid2_d;

    always_comb begin
        a_data2_d  = a_data_q;
        b_data2_d  = b_data_q;
        a_valid2_d = a_valid_q;
        b_valid2_d = b_valid_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            a_data2_q  <= '0;
            b_data2_q  <= '0;
            a_valid2_q <= 1'b0;
            b_valid2_q <= 1'b0;
        end else begin
            a_data2_q  <= a_data2_d;
            b_data2_q  <= b_data2_d;
            a_valid2_q <= a_valid2_d;
            b_valid2_q <= b_valid2_d;
        end
    end

    assign a_data_out = a_data2_q;
    assign b_data_out = b_data2_q;
    assign a_valid    = a_valid2_q;
    assign b_valid    = b_valid2_q;
`else
    assign a_data_out = a_data_q;
    assign b_data_out = b_data_q;
    assign a_valid    = a_valid_q;
    assign b_valid    = b_valid_q;
`endif

endmodule

// File: tb/tb_rams_dp_rf_clr.sv
// -----------------------------------------------------------------------------
// tb_rams_dp_rf_clr
//
// Directed bench for rams_dp_rf_clr. Main instance: MEM_WIDTH=8, MEM_DEPTH=16.
// Second instance: MEM_DEPTH=12 for the non-power-of-two sweep and
// out-of-range write. Read latency follows RAMS_DP_OUTREG_EN.
// -----------------------------------------------------------------------------
module tb_rams_dp_rf_clr;
    localparam int W = 8;
`ifdef RAMS_DP_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // ---------------- DUT signals ----------------
    logic         clear_start = 1'b0;
    logic         busy;
    logic         a_enable = 1'b0, a_write_en = 1'b0;
    logic [3:0]   a_address = '0;
    logic [W-1:0] a_data_in = '0;
    logic [W-1:0] a_data_out;
    logic         a_valid;
    logic         b_enable = 1'b0, b_write_en = 1'b0;
    logic [3:0]   b_address = '0;
    logic [W-1:0] b_data_in = '0;
    logic [W-1:0] b_data_out;
    logic         b_valid;

    logic         busy12;
    logic         c_enable = 1'b0, c_write_en = 1'b0;
    logic [3:0]   c_address = '0;
    logic [W-1:0] c_data_in = '0;
    logic [W-1:0] c_data_out;
    logic         c_valid;
    logic [W-1:0] d_data_out;
    logic         d_valid;

    rams_dp_rf_clr #(.MEM_WIDTH(W), .MEM_DEPTH(16)) dut (
        .clock(clock), .reset(reset), .clear_start(clear_start), .busy(busy),
        .a_enable(a_enable), .a_write_en(a_write_en), .a_address(a_address),
        .a_data_in(a_data_in), .a_data_out(a_data_out), .a_valid(a_valid),
        .b_enable(b_enable), .b_write_en(b_write_en), .b_address(b_address),
        .b_data_in(b_data_in), .b_data_out(b_data_out), .b_valid(b_valid)
    );

    rams_dp_rf_clr #(.MEM_WIDTH(W), .MEM_DEPTH(12)) dut12 (
        .clock(clock), .reset(reset), .clear_start(1'b0), .busy(busy12),
        .a_enable(c_enable), .a_write_en(c_write_en), .a_address(c_address),
        .a_data_in(c_data_in), .a_data_out(c_data_out), .a_valid(c_valid),
        .b_enable(1'b0), .b_write_en(1'b0), .b_address(4'd0),
        .b_data_in(8'h00), .b_data_out(d_data_out), .b_valid(d_valid)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_bad    = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One accepted-access cycle on both ports of dut, then wait out the latency
    // so the outputs show the result of this access.
    task automatic access(input logic ae, input logic awe, input logic [3:0] aa, input logic [W-1:0] ad,
                          input logic be, input logic bwe, input logic [3:0] ba, input logic [W-1:0] bd);
        a_enable = ae; a_write_en = awe; a_address = aa; a_data_in = ad;
        b_enable = be; b_write_en = bwe; b_address = ba; b_data_in = bd;
        tick();
        a_enable = 1'b0; a_write_en = 1'b0;
        b_enable = 1'b0; b_write_en = 1'b0;
        repeat (LAT - 1) tick();
    endtask

    task automatic access12(input logic we, input logic [3:0] addr, input logic [W-1:0] din);
        c_enable = 1'b1; c_write_en = we; c_address = addr; c_data_in = din;
        tick();
        c_enable = 1'b0; c_write_en = 1'b0;
        repeat (LAT - 1) tick();
    endtask

    // Count cycles with busy high, starting at the current sample point.
    task automatic count_busy(output int cnt);
        int guard;
        cnt = 0;
        guard = 0;
        while (busy && guard < 200) begin
            cnt++;
            guard++;
            tick();
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int cnt16, cnt12, guard;
        logic [9:0] pat;

        // Reset held 3 cycles
        reset = 1'b1;
        repeat (3) tick();
        check("rst_busy", busy, 1);
        check("rst_a_data", a_data_out, 0);
        check("rst_a_valid", a_valid, 0);
        check("rst_b_data", b_data_out, 0);
        check("rst_b_valid", b_valid, 0);
        check("rst_busy12", busy12, 1);

        // Startup sweep lengths: 16 words and 12 words
        reset = 1'b0;
        cnt16 = 0; cnt12 = 0; guard = 0;
        while ((busy || busy12) && guard < 200) begin
            if (busy) cnt16++;
            if (busy12) cnt12++;
            guard++;
            tick();
        end
        check("startup_busy16", cnt16, 16);
        check("startup_busy12", cnt12, 12);

        // Every word reads zero on both ports
        for (int i = 0; i < 16; i++) begin
            access(1, 0, 4'(i), 8'h00, 1, 0, 4'(15 - i), 8'h00);
            exp_q.push_back(8'h00);
            exp_q.push_back(8'h00);
            check("init_a_data", a_data_out, exp_q.pop_front());
            check("init_a_valid", a_valid, 1);
            check("init_b_data", b_data_out, exp_q.pop_front());
            check("init_b_valid", b_valid, 1);
        end
        tick();
        check("idle_a_valid", a_valid, 0);
        check("idle_b_valid", b_valid, 0);

        // A writes 3=A5 (reads old 00), then B reads 3
        access(1, 1, 4'd3, 8'hA5, 0, 0, 4'd0, 8'h00);
        check("wr3_a_valid", a_valid, 1);
        check("wr3_a_old", a_data_out, 8'h00);
        access(0, 0, 4'd0, 8'h00, 1, 0, 4'd3, 8'h00);
        check("rd3_b_data", b_data_out, 8'hA5);
        check("rd3_b_valid", b_valid, 1);
        check("rd3_a_valid", a_valid, 0);
        tick();
        check("hold_b_valid", b_valid, 0);
        check("hold_b_data", b_data_out, 8'hA5);

        // Write/write collision at 5: A wins
        access(1, 1, 4'd5, 8'h11, 1, 1, 4'd5, 8'h22);
        check("ww5_a_old", a_data_out, 8'h00);
        check("ww5_b_old", b_data_out, 8'h00);
        access(1, 0, 4'd5, 8'h00, 1, 0, 4'd5, 8'h00);
        check("ww5_a_rd", a_data_out, 8'h11);
        check("ww5_b_rd", b_data_out, 8'h11);

        // Write/read collision at 6: reader sees old data
        access(1, 1, 4'd6, 8'h33, 0, 0, 4'd0, 8'h00);
        access(1, 1, 4'd6, 8'h44, 1, 0, 4'd6, 8'h00);
        check("wr6_b_old", b_data_out, 8'h33);
        check("wr6_a_old", a_data_out, 8'h33);
        access(0, 0, 4'd0, 8'h00, 1, 0, 4'd6, 8'h00);
        check("wr6_b_new", b_data_out, 8'h44);

        // Fill memory, then leave recognisable data on the outputs
        for (int i = 0; i < 8; i++)
            access(1, 1, 4'(i), 8'(8'h80 + i), 1, 1, 4'(i + 8), 8'(8'h88 + i));
        access(1, 0, 4'd3, 8'h00, 1, 0, 4'd12, 8'h00);
        check("fill_a3", a_data_out, 8'h83);
        check("fill_b12", b_data_out, 8'h8C);
        check("pre_clear_busy", busy, 0);

        // Clear sweep: accesses during busy are dropped, outputs hold
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        a_enable = 1'b1; a_write_en = 1'b1; a_address = 4'd2; a_data_in = 8'hEE;
        b_enable = 1'b1; b_write_en = 1'b0; b_address = 4'd3;
        cnt16 = 0; guard = 0;
        while (busy && guard < 200) begin
            cnt16++;
            guard++;
            check("clr_a_valid", a_valid, 0);
            check("clr_b_valid", b_valid, 0);
            check("clr_a_hold", a_data_out, 8'h83);
            check("clr_b_hold", b_data_out, 8'h8C);
            tick();
        end
        a_enable = 1'b0; a_write_en = 1'b0; b_enable = 1'b0;
        check("clear_busy16", cnt16, 16);
        for (int i = 0; i < 16; i++) begin
            access(1, 0, 4'(i), 8'h00, 1, 0, 4'(i), 8'h00);
            exp_q.push_back(8'h00);
            check("swept_a", a_data_out, exp_q.pop_front());
            check("swept_b", b_data_out, 8'h00);
        end

        // Reset at sweep index 8 restarts a full sweep
        access(1, 1, 4'd12, 8'h5A, 0, 0, 4'd0, 8'h00);
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        repeat (8) tick();
        reset = 1'b1;
        repeat (2) tick();
        check("midsweep_rst_busy", busy, 1);
        reset = 1'b0;
        count_busy(cnt16);
        check("restart_busy16", cnt16, 16);
        access(1, 0, 4'd12, 8'h00, 0, 0, 4'd0, 8'h00);
        check("restart_a12", a_data_out, 8'h00);

        // Reset with a read in flight zeroes every output stage
        access(1, 1, 4'd9, 8'h99, 0, 0, 4'd0, 8'h00);
        a_enable = 1'b1; a_address = 4'd9;
        b_enable = 1'b1; b_address = 4'd9;
        tick();
        a_enable = 1'b0; b_enable = 1'b0;
        reset = 1'b1;
        tick();
        check("pipe_rst_a_data", a_data_out, 0);
        check("pipe_rst_a_valid", a_valid, 0);
        check("pipe_rst_b_data", b_data_out, 0);
        check("pipe_rst_b_valid", b_valid, 0);
        reset = 1'b0;
        count_busy(cnt16);
        check("pipe_rst_busy16", cnt16, 16);

        // Enable gaps reappear on valid, delayed by the read latency
        pat = 10'b0110100011;
        for (int i = 0; i < 10 + LAT - 1; i++) begin
            a_enable = (i < 10) ? pat[i] : 1'b0;
            a_address = 4'(i);
            tick();
            if (i >= LAT - 1)
                check("gap_a_valid", a_valid, pat[i - LAT + 1]);
        end
        a_enable = 1'b0;

        // Depth 12: out-of-range write leaves words 0..11 untouched
        for (int i = 0; i < 12; i++)
            access12(1, 4'(i), 8'(8'h30 + i));
        access12(1, 4'd13, 8'hFF);
        check("oor_valid", c_valid, 1);
        for (int i = 0; i < 12; i++) begin
            access12(0, 4'(i), 8'h00);
            exp_q.push_back(8'(8'h30 + i));
            check("oor_word", c_data_out, exp_q.pop_front());
        end
        check("d12_b_valid", d_valid, 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    // Hard time limit in case the sequence stalls
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
